// File: rtl/alu_seq.sv
// alu_seq: bus-master sequencer driving the shared tri-state ALU bus.
// Define ALU_SEQ_CMDBUF_EN to add a 1-entry command holding register.
module alu_seq #(
    parameter int  OP_W       = 8,
    parameter int  ADDR_W     = 8,
    parameter int  RESULT_LAT = 3,
    localparam int BW         = OP_W + ADDR_W
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [OP_W-1:0] cmd_opcode,
    input  logic [BW-1:0]   cmd_operand,
    output logic [OP_W-1:0] alu_opcode,
    output logic            alu_valid,
    input  logic            alu_zero,
    inout  wire  [BW-1:0]   alu_bus,
    output logic            rsp_valid,
    output logic [BW-1:0]   rsp_data,
    output logic            rsp_zero,
    output logic            busy
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RESULT_LAT - 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_CAPTURE
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [OP_W-1:0]  r_alu_opcode;
    logic [BW-1:0]    r_operand;
    logic             r_alu_valid;
    logic             r_rsp_valid;
    logic [BW-1:0]    r_rsp_data;
    logic             r_rsp_zero;

    logic             w_accept;
    logic             w_load;
    logic [OP_W-1:0]  w_ld_op;
    logic [BW-1:0]    w_ld_opnd;

`ifdef ALU_SEQ_CMDBUF_EN
    logic             r_buf_full;
    logic [OP_W-1:0]  r_buf_op;
    logic [BW-1:0]    r_buf_opnd;

    assign cmd_ready = nrst && !r_buf_full;
`else
    assign cmd_ready = nrst && (r_state == S_IDLE);
`endif

    assign w_accept   = cmd_valid && cmd_ready;
    // The bus is owned only for the single DRIVE cycle.
    assign alu_bus    = r_alu_valid ? r_operand : {BW{1'bz}};
    assign alu_valid  = r_alu_valid;
    assign alu_opcode = r_alu_opcode;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_zero   = r_rsp_zero;
    assign busy       = (r_state != S_IDLE);

    always_comb begin
        w_load    = 1'b0;
        w_ld_op   = cmd_opcode;
        w_ld_opnd = cmd_operand;
        if (r_state == S_IDLE) begin
            w_load = w_accept;
        end
`ifdef ALU_SEQ_CMDBUF_EN
        // A held command wins; otherwise a fresh one goes straight to DRIVE.
        if (r_state == S_CAPTURE) begin
            w_load = r_buf_full || w_accept;
            if (r_buf_full) begin
                w_ld_op   = r_buf_op;
                w_ld_opnd = r_buf_opnd;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_alu_opcode <= '0;
            r_operand    <= '0;
            r_alu_valid  <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_zero   <= 1'b0;
`ifdef ALU_SEQ_CMDBUF_EN
            r_buf_full   <= 1'b0;
            r_buf_op     <= '0;
            r_buf_opnd   <= '0;
`endif
        end else begin
            r_alu_valid <= 1'b0;
            r_rsp_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_state <= S_IDLE;
                end
                S_DRIVE: begin
                    r_state <= (RESULT_LAT == 2) ? S_CAPTURE : S_WAIT;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_data  <= alu_bus;
                    r_rsp_zero  <= alu_zero;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (w_load) begin
                r_state      <= S_DRIVE;
                r_cnt        <= CNT_INIT;
                r_alu_opcode <= w_ld_op;
                r_operand    <= w_ld_opnd;
                r_alu_valid  <= 1'b1;
            end

`ifdef ALU_SEQ_CMDBUF_EN
            if (r_state == S_CAPTURE) begin
                r_buf_full <= 1'b0;
            end
            if (w_accept && (r_state == S_DRIVE || r_state == S_WAIT)) begin
                r_buf_full <= 1'b1;
                r_buf_op   <= cmd_opcode;
                r_buf_opnd <= cmd_operand;
            end
`endif
        end
    end

endmodule
